// File: rtl/ampl_peak.sv
// ampl_peak: complex-bin power or integer magnitude, with per-frame bin index and peak tracking.
module ampl_peak #(
  parameter int W = 16,
  parameter int FRAME_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic [W-1:0]          x,
  input  logic [W-1:0]          y,
  input  logic                  mode,
  input  logic                  frame_clr,
  output logic [2*W-1:0]        result,
  output logic                  done,
  output logic [FRAME_LOG2-1:0] bin_idx,
  output logic [2*W-1:0]        peak_val,
  output logic [FRAME_LOG2-1:0] peak_idx,
  output logic                  frame_done
);
  typedef enum logic [2:0] {IDLE, SQR, ADD, ROOT, FIN} state_t;
  localparam int CW = $clog2(W + 1);
  state_t state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d, root_q, root_d;
  logic mode_q, mode_d, frame_done_q, frame_done_d;
  logic [2*W-1:0] sqx_q, sqx_d, sqy_q, sqy_d, rad_q, rad_d;
  logic [2*W-1:0] result_q, result_d, peak_val_q, peak_val_d, res_val;
  logic [W+1:0] rem_q, rem_d, rem_sh, trial;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FRAME_LOG2-1:0] bin_q, bin_d, bin_idx_q, bin_idx_d, peak_idx_q, peak_idx_d, bin_cur;
  logic signed [2*W-1:0] xe, ye;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    mode_d = mode_q;
    sqx_d = sqx_q;
    sqy_d = sqy_q;
    rad_d = rad_q;
    rem_d = rem_q;
    root_d = root_q;
    cnt_d = cnt_q;
    result_d = result_q;
    bin_d = bin_q;
    bin_idx_d = bin_idx_q;
    peak_val_d = peak_val_q;
    peak_idx_d = peak_idx_q;
    frame_done_d = 1'b0;
    xe = $signed(x_q);
    ye = $signed(y_q);
    // radicand is consumed two bits per cycle from its top end
    rem_sh = (rem_q << 2) | (W+2)'(rad_q[2*W-1 -: 2]);
    trial = {root_q, 2'b01};
    res_val = mode_q ? rad_q : {{W{1'b0}}, root_q};
    bin_cur = frame_clr ? '0 : bin_q;
    if (frame_clr) begin
      bin_d = '0;
      peak_val_d = '0;
      peak_idx_d = '0;
    end
    case (state_q)
      IDLE: if (start) begin
        x_d = x;
        y_d = y;
        mode_d = mode;
        state_d = SQR;
      end
      SQR: begin
        sqx_d = xe * xe;
        sqy_d = ye * ye;
        state_d = ADD;
      end
      ADD: begin
        rad_d = sqx_q + sqy_q;
        rem_d = '0;
        root_d = '0;
        cnt_d = '0;
        state_d = mode_q ? FIN : ROOT;
      end
      ROOT: begin
        rad_d = rad_q << 2;
        rem_d = rem_sh >= trial ? rem_sh - trial : rem_sh;
        root_d = {root_q[W-2:0], rem_sh >= trial};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(W - 1) ? FIN : ROOT;
      end
      FIN: begin
        // a same-edge frame_clr forces this result to bin 0, so it seeds the peak
        result_d = res_val;
        bin_idx_d = bin_cur;
        bin_d = bin_cur + 1'b1;
        if (bin_cur == '0 || res_val > peak_val_q) begin
          peak_val_d = res_val;
          peak_idx_d = bin_cur;
        end
        frame_done_d = &bin_cur;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      mode_q <= 1'b0;
      sqx_q <= '0;
      sqy_q <= '0;
      rad_q <= '0;
      rem_q <= '0;
      root_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      bin_q <= '0;
      bin_idx_q <= '0;
      peak_val_q <= '0;
      peak_idx_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      mode_q <= mode_d;
      sqx_q <= sqx_d;
      sqy_q <= sqy_d;
      rad_q <= rad_d;
      rem_q <= rem_d;
      root_q <= root_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      bin_q <= bin_d;
      bin_idx_q <= bin_idx_d;
      peak_val_q <= peak_val_d;
      peak_idx_q <= peak_idx_d;
      frame_done_q <= frame_done_d;
    end
  assign result = result_q;
  assign done = state_q == IDLE;
  assign bin_idx = bin_idx_q;
  assign peak_val = peak_val_q;
  assign peak_idx = peak_idx_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ampl_peak.sv
// tb_ampl_peak: directed and random ops against an arithmetic model of power, isqrt and frame peak.
module tb_ampl_peak;
  localparam int W = 16;
  localparam int FL = 2;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic mode = 1'b0;
  logic frame_clr = 1'b0;
  logic [2*W-1:0] result, peak_val;
  logic done, frame_done;
  logic [FL-1:0] bin_idx, peak_idx;
  int checks = 0, errors = 0;
  longint m_cnt = 0, m_pk = 0, m_pi = 0;
  longint res;
  ampl_peak #(.W(W), .FRAME_LOG2(FL)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .x(x), .y(y), .mode(mode),
    .frame_clr(frame_clr), .result(result), .done(done), .bin_idx(bin_idx),
    .peak_val(peak_val), .peak_idx(peak_idx), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  function automatic longint isqrt(input longint p);
    longint r = 0;
    for (longint b = 65536; b > 0; b = b / 2)
      if ((r + b) * (r + b) <= p) r = r + b;
    return r;
  endfunction
  task automatic run(input int xi, input int yi, input bit mi, input bit hold, input int clr_at, output longint r);
    int lat;
    longint p, exp_r, bin;
    @(negedge clk);
    start = 1'b1;
    x = 16'(xi);
    y = 16'(yi);
    mode = mi;
    @(negedge clk);
    start = hold;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == clr_at) begin
        frame_clr = 1'b1;
        m_cnt = 0;
        m_pk = 0;
        m_pi = 0;
      end
      @(negedge clk);
      if (frame_clr) begin
        frame_clr = 1'b0;
        check("clr_peak", longint'(peak_val), 0);
      end
      lat++;
    end
    start = 1'b0;
    check("latency", lat, mi ? 4 : W + 4);
    p = longint'(xi) * xi + longint'(yi) * yi;
    exp_r = mi ? p : isqrt(p);
    bin = m_cnt;
    m_cnt = (m_cnt + 1) % (1 << FL);
    if (bin == 0 || exp_r > m_pk) begin
      m_pk = exp_r;
      m_pi = bin;
    end
    check("result", longint'(result), exp_r);
    check("bin_idx", longint'(bin_idx), bin);
    check("peak_val", longint'(peak_val), m_pk);
    check("peak_idx", longint'(peak_idx), m_pi);
    check("frame_done", longint'(frame_done), longint'(bin == (1 << FL) - 1));
    r = longint'(result);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_done"}, longint'(done), 1);
    check({tag, "_result"}, longint'(result), 0);
    check({tag, "_bin"}, longint'(bin_idx), 0);
    check({tag, "_peak"}, longint'(peak_val), 0);
    check({tag, "_pidx"}, longint'(peak_idx), 0);
    check({tag, "_fdone"}, longint'(frame_done), 0);
  endtask
  initial begin
    logic signed [W-1:0] rx, ry;
    bit rm;
    #12;
    check_zero("reset");
    @(negedge clk);
    n_reset = 1'b1;
    run(3, 4, 1, 0, -1, res);
    check("pow_3_4", res, 25);
    run(3, -4, 0, 0, -1, res);
    check("mag_3_m4", res, 5);
    run(1, 1, 0, 0, -1, res);
    check("mag_1_1", res, 1);
    run(0, 0, 0, 0, -1, res);
    check("mag_0_0", res, 0);
    run(-32768, -32768, 0, 0, -1, res);
    check("mag_min", res, 46340);
    run(-32768, -32768, 1, 0, -1, res);
    check("pow_min", res, 64'h8000_0000);
    run(7, 0, 0, 1, -1, res);
    @(negedge clk);
    check("busy_idle", longint'(done), 1);
    run(2, 0, 1, 0, -1, res);
    check("busy_bin", longint'(bin_idx), 3);
    run(1, 0, 1, 0, -1, res);
    run(0, 3, 1, 0, -1, res);
    run(3, 0, 1, 0, -1, res);
    run(2, 2, 1, 0, -1, res);
    check("frame_pk", longint'(peak_val), 9);
    check("frame_pi", longint'(peak_idx), 1);
    @(negedge clk);
    check("fdone_pulse", longint'(frame_done), 0);
    run(1, 1, 1, 0, -1, res);
    check("next_pk", longint'(peak_val), 2);
    check("next_pi", longint'(peak_idx), 0);
    run(5, 5, 0, 0, 5, res);
    check("clr_bin", longint'(bin_idx), 0);
    run(1, 2, 0, 0, -1, res);
    check("clr_cont", longint'(bin_idx), 1);
    @(negedge clk);
    start = 1'b1;
    x = 16'(100);
    y = 16'(200);
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 n_reset = 1'b0;
    #1 check_zero("abort");
    m_cnt = 0;
    m_pk = 0;
    m_pi = 0;
    @(negedge clk);
    n_reset = 1'b1;
    run(6, 8, 0, 0, -1, res);
    check("after_abort", res, 10);
    for (int i = 0; i < 48; i++) begin
      if (m_cnt == 0) rm = 1'($urandom);
      rx = W'($urandom);
      ry = W'($urandom);
      run(int'(rx), int'(ry), rm, 0, -1, res);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ampl_peak.md
# ampl_peak

Parametrised fixed-point successor of the amplitude stage. It takes one signed complex bin (x, y) per start strobe and returns either the exact power x²+y² or the integer magnitude floor(sqrt(x²+y²)). It also tracks bin index and the per-frame peak, so the FFT back-end can report the dominant bin without a second pass. It sits between the FFT output buffer and the spectrum readout logic and has no dependency on the FP cores.

## Interface
- W, 16: input component width (signed two's complement), W ≥ 4
- FRAME_LOG2, 8: bins per frame = 2^FRAME_LOG2
- clk  in  1  clock, rising edge
- n_reset  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only while done=1
- x  in  W  real part, signed
- y  in  W  imaginary part, signed
- mode  in  1  0 = magnitude, 1 = power; captured with start
- frame_clr  in  1  synchronous clear of bin counter and peak tracker
- result  out  2W  power (full width) or magnitude (zero-extended from W bits)
- done  out  1  1 = idle with result valid; 0 = busy
- bin_idx  out  FRAME_LOG2  bin index of current result
- peak_val  out  2W  largest result in current frame
- peak_idx  out  FRAME_LOG2  bin index of peak_val
- frame_done  out  1  one-cycle pulse when the last bin of a frame completes

## Operation
- States: IDLE, SQR, ADD, ROOT, FIN.
- IDLE: done=1. If start=1 at an edge, capture x, y and mode, set done=0, and go to SQR. start in any other state is ignored. Requests are not queued.
- SQR: register x*x and y*y as unsigned 2W-bit values. The max is (−2^(W-1))² = 2^(2W-2).
- ADD: register sum = x²+y² as a 2W-bit value, with max 2^(2W-1). No overflow is possible. Next state is FIN if mode=1, else ROOT.
- ROOT: restoring digit-by-digit square root, one result bit per cycle, MSB first, W cycles. Output is floor(sqrt(sum)), always < 2^W.
- FIN: load result, then update bin and peak:
  - bin_idx = bin counter value; counter increments and wraps at 2^FRAME_LOG2.
  - If bin_idx = 0, load peak_val and peak_idx unconditionally.
  - Otherwise load them only if result > peak_val (strict, so the first occurrence wins).
  - frame_done=1 for one cycle if bin_idx = 2^FRAME_LOG2−1.
  - Set done=1 and go to IDLE.
- result, bin_idx, peak_val and peak_idx hold between FIN cycles. peak_val and peak_idx stay valid after frame_done until the next frame's bin 0 completes.
- Peak comparison is on raw result values. mode must stay constant within a frame; mixed-mode frames give peak values of no defined meaning, but the logic does not lock up.
- frame_clr:
  - Next edge zeroes the bin counter, peak_val and peak_idx.
  - Any in-flight or same-edge-accepted request completes as bin 0.
  - If frame_clr and FIN occur on the same edge, the clear wins: that result is reported as bin 0 and loads the peak.

## Timing
- Reset: state IDLE, done=1, result=0, bin_idx=0, peak_val=0, peak_idx=0, frame_done=0, bin counter=0.
- Assertion of n_reset mid-operation aborts the computation immediately. No FIN occurs and the counter is not advanced.
- Latency, with the start edge counted as edge 0:
  - Power mode: done rises after edge 3, giving 4 cycles.
  - Magnitude mode: done rises after edge 3+W, giving 4+W cycles (20 for W=16).
- Back-to-back operation: start may be held high. A new request is accepted on the first edge with done=1, which is the edge after done rises.
  - Power throughput: 1 result per 4 cycles.
  - Magnitude throughput: 1 result per W+4 cycles.
- frame_done is high in the same cycle done first reads 1 for the last bin.
- result and the peak outputs change only on FIN edges, frame_clr edges or reset.

## Test plan
- Power, W=16: x=3, y=4, mode=1 → result=25 and done=1 exactly 4 cycles after the start edge. done=0 in between.
- Magnitude, W=16: x=3, y=−4, mode=0 → result=5 at 20 cycles. Also x=1, y=1 → 1, x=0, y=0 → 0, and x=y=−32768 → 46340. Power for x=y=−32768 → 0x80000000.
- Busy rejection: start pulsed on every cycle during a magnitude op → exactly one result, and bin_idx advances by 1.
- Frame peak, FRAME_LOG2=2, power mode: bins (1,0), (0,3), (3,0), (2,2) → results 1, 9, 9, 8; peak_val=9; peak_idx=1; frame_done pulses once at bin 3. The next frame's bin 0 = (1,1) → peak_val=2, peak_idx=0.
- frame_clr asserted mid-frame while busy → completing result reports bin_idx=0 and loads the peak. Counter continues from 1.
- n_reset asserted during ROOT → done=1 and all outputs 0 immediately. A subsequent x=6, y=8 magnitude → result=10, bin_idx=0.
